// File: rtl/srv_icb_dec_buf.sv
// srv_icb_dec_buf: ICB ingress stage with address decode,
// command/response FIFOs and an outstanding-transaction limit.
module srv_icb_dec_buf #(
  parameter int G_DS_NUM    = 2,
  parameter int G_W_ADDR    = 32,
  parameter int G_W_DATA    = 32,
  parameter int G_CMD_DEPTH = 2,
  parameter int G_RSP_DEPTH = 2,
  parameter int G_MPX       = 2,
  parameter logic [G_W_ADDR-1:0] G_BASE [G_DS_NUM] =
    '{32'h0000_0000, 32'h1000_0000},
  parameter logic [G_W_ADDR-1:0] G_MASK [G_DS_NUM] =
    '{32'hF000_0000, 32'hF000_0000}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  active,
  output logic                  us_cmd_ready,
  input  logic                  us_cmd_valid,
  input  logic [G_W_ADDR-1:0]   us_cmd_addr,
  input  logic                  us_cmd_read,
  input  logic [G_W_DATA-1:0]   us_cmd_wdata,
  input  logic [G_W_DATA/8-1:0] us_cmd_wmask,
  input  logic                  us_resp_ready,
  output logic                  us_resp_valid,
  output logic [G_W_DATA-1:0]   us_resp_rdata,
  output logic                  us_resp_err,
  input  logic                  ds_cmd_ready,
  output logic                  ds_cmd_valid,
  output logic [G_DS_NUM-1:0]   ds_cmd_hit,
  output logic [G_W_ADDR-1:0]   ds_cmd_addr,
  output logic                  ds_cmd_read,
  output logic [G_W_DATA-1:0]   ds_cmd_wdata,
  output logic [G_W_DATA/8-1:0] ds_cmd_wmask,
  output logic                  ds_resp_ready,
  input  logic                  ds_resp_valid,
  input  logic [G_W_DATA-1:0]   ds_resp_rdata,
  input  logic                  ds_resp_err
);

  localparam int WM  = G_W_DATA / 8;
  localparam int CPW =
    (G_CMD_DEPTH > 1) ? $clog2(G_CMD_DEPTH) : 1;
  localparam int RPW =
    (G_RSP_DEPTH > 1) ? $clog2(G_RSP_DEPTH) : 1;
  localparam int CCW = $clog2(G_CMD_DEPTH + 1);
  localparam int RCW = $clog2(G_RSP_DEPTH + 1);
  localparam int OW  = $clog2(G_MPX + 1);

  localparam logic [CPW-1:0] CMD_LAST = CPW'(G_CMD_DEPTH - 1);
  localparam logic [RPW-1:0] RSP_LAST = RPW'(G_RSP_DEPTH - 1);
  localparam logic [CCW-1:0] CMD_FULL = CCW'(G_CMD_DEPTH);
  localparam logic [RCW-1:0] RSP_FULL = RCW'(G_RSP_DEPTH);
  localparam logic [OW-1:0]  OSD_MAX  = OW'(G_MPX);

  typedef struct packed {
    logic [G_DS_NUM-1:0] hit;
    logic [G_W_ADDR-1:0] addr;
    logic                read;
    logic [G_W_DATA-1:0] wdata;
    logic [WM-1:0]       wmask;
  } cmd_t;

  typedef struct packed {
    logic [G_W_DATA-1:0] rdata;
    logic                err;
  } rsp_t;

  cmd_t cmd_mem [G_CMD_DEPTH];
  rsp_t rsp_mem [G_RSP_DEPTH];
  cmd_t cmd_head;
  rsp_t rsp_head;

  logic [CPW-1:0] cmd_wp, cmd_rp;
  logic [RPW-1:0] rsp_wp, rsp_rp;
  logic [CCW-1:0] cmd_cnt;
  logic [RCW-1:0] rsp_cnt;
  logic [OW-1:0]  osd;
  logic           init;

  logic [G_DS_NUM-1:0] raw, hit;
  logic cmd_push, cmd_pop, rsp_push, rsp_pop;

  always_comb begin
    raw = '0;
    for (int k = 0; k < G_DS_NUM; k++)
      raw[k] = (us_cmd_addr & G_MASK[k]) == G_BASE[k];
  end

  // Lowest matching region wins on overlap.
  assign hit = raw & (~raw + 1'b1);

  assign cmd_push = us_cmd_valid & us_cmd_ready;
  assign cmd_pop  = ds_cmd_valid & ds_cmd_ready;
  assign rsp_push = ds_resp_valid & ds_resp_ready;
  assign rsp_pop  = us_resp_valid & us_resp_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init    <= 1'b0;
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      rsp_wp  <= '0;
      rsp_rp  <= '0;
      rsp_cnt <= '0;
      osd     <= '0;
    end else begin
      init <= 1'b1;
      if (cmd_push)
        cmd_wp <= (cmd_wp == CMD_LAST) ? '0 : cmd_wp + 1'b1;
      if (cmd_pop)
        cmd_rp <= (cmd_rp == CMD_LAST) ? '0 : cmd_rp + 1'b1;
      if (cmd_push & ~cmd_pop)
        cmd_cnt <= cmd_cnt + 1'b1;
      else if (~cmd_push & cmd_pop)
        cmd_cnt <= cmd_cnt - 1'b1;
      if (rsp_push)
        rsp_wp <= (rsp_wp == RSP_LAST) ? '0 : rsp_wp + 1'b1;
      if (rsp_pop)
        rsp_rp <= (rsp_rp == RSP_LAST) ? '0 : rsp_rp + 1'b1;
      if (rsp_push & ~rsp_pop)
        rsp_cnt <= rsp_cnt + 1'b1;
      else if (~rsp_push & rsp_pop)
        rsp_cnt <= rsp_cnt - 1'b1;
      // Stray responses with nothing outstanding do not underflow.
      if (cmd_pop & ~rsp_push)
        osd <= osd + 1'b1;
      else if (~cmd_pop & rsp_push & (osd != '0))
        osd <= osd - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[cmd_wp] <= {hit, us_cmd_addr, us_cmd_read,
                          us_cmd_wdata, us_cmd_wmask};
    if (rsp_push)
      rsp_mem[rsp_wp] <= {ds_resp_rdata, ds_resp_err};
  end

  assign cmd_head = cmd_mem[cmd_rp];
  assign rsp_head = rsp_mem[rsp_rp];

  assign us_cmd_ready  = init & (cmd_cnt != CMD_FULL);
  assign ds_cmd_valid  = (cmd_cnt != '0) & (osd != OSD_MAX);
  assign ds_resp_ready = init & (rsp_cnt != RSP_FULL);
  assign us_resp_valid = (rsp_cnt != '0);
  assign active = (cmd_cnt != '0) | (rsp_cnt != '0) |
                  (osd != '0);

  assign ds_cmd_hit    = cmd_head.hit;
  assign ds_cmd_addr   = cmd_head.addr;
  assign ds_cmd_read   = cmd_head.read;
  assign ds_cmd_wdata  = cmd_head.wdata;
  assign ds_cmd_wmask  = cmd_head.wmask;
  assign us_resp_rdata = rsp_head.rdata;
  assign us_resp_err   = rsp_head.err;

endmodule

// File: doc/srv_icb_dec_buf.md
# srv_icb_dec_buf

Upstream ICB ingress stage placed between one bus master and one upstream port of the N-to-N ICB crossbar. It decodes each command address into the crossbar's one-hot `hit` vector and buffers commands and responses in small FIFOs. It also limits in-flight transactions so the crossbar port's pending-transaction budget is never exceeded. A zero hit vector sends the command to the crossbar's default slave.

## Interface
Parameters:
- G_DS_NUM, 2, number of decoded downstream slaves (hit width)
- G_W_ADDR, 32, address width
- G_W_DATA, 32, data width; wmask width is G_W_DATA/8
- G_CMD_DEPTH, 2, command FIFO entries (>=1)
- G_RSP_DEPTH, 2, response FIFO entries (>=1)
- G_MPX, 2, max outstanding downstream transactions (>=1)
- G_BASE[G_DS_NUM], '{32'h0000_0000, 32'h1000_0000}, region base per slave
- G_MASK[G_DS_NUM], '{32'hF000_0000, 32'hF000_0000}, region compare mask per slave

Ports:
- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  reset; one clock, synchronous, active-low
- active  out  1  any FIFO non-empty or outstanding count non-zero
- us_cmd_ready / us_cmd_valid  out / in  1 / 1  master command handshake
- us_cmd_addr  in  G_W_ADDR  command address
- us_cmd_read  in  1  1 = read, 0 = write
- us_cmd_wdata  in  G_W_DATA  write data
- us_cmd_wmask  in  G_W_DATA/8  byte enables
- us_resp_ready / us_resp_valid  in / out  1 / 1  master response handshake
- us_resp_rdata  out  G_W_DATA  read data
- us_resp_err  out  1  error flag
- ds_cmd_ready / ds_cmd_valid  in / out  1 / 1  crossbar command handshake
- ds_cmd_hit  out  G_DS_NUM  decoded one-hot or zero slave select
- ds_cmd_addr, ds_cmd_read, ds_cmd_wdata, ds_cmd_wmask  out  as us_*  buffered command fields
- ds_resp_ready / ds_resp_valid  out / in  1 / 1  crossbar response handshake
- ds_resp_rdata  in  G_W_DATA  read data
- ds_resp_err  in  1  error flag

## Operation
- **Address decode:** performed at command FIFO write. `raw[k] = ((us_cmd_addr & G_MASK[k]) == G_BASE[k])`. The stored hit keeps only the lowest set bit of `raw`, so overlapping regions resolve to the lowest index. `raw == 0` stores hit 0, which selects the default slave.
- **Command FIFO:**
  - Holds `{hit, addr, read, wdata, wmask}`.
  - Push on `us_cmd_valid & us_cmd_ready`; pop on `ds_cmd_valid & ds_cmd_ready`.
  - Circular read/write pointers wrap from G_CMD_DEPTH-1 to 0. Occupancy counter runs 0..G_CMD_DEPTH.
- **Response FIFO:**
  - Holds `{rdata, err}`.
  - Push on `ds_resp_valid & ds_resp_ready`; pop on `us_resp_valid & us_resp_ready`.
  - Same pointer and occupancy scheme, sized G_RSP_DEPTH.
- **Outstanding counter `osd`:**
  - Range 0..G_MPX.
  - +1 on a downstream command handshake, -1 on a downstream response handshake, unchanged when both occur in the same cycle.
  - Saturates at 0: a response arriving with `osd == 0` is still buffered and does not underflow the counter.
- **Init flag:** a register cleared by reset and set at the first clock edge where reset_n is sampled high.
- **Output equations:**
  - `us_cmd_ready = init & (cmd_cnt != G_CMD_DEPTH)`
  - `ds_cmd_valid = (cmd_cnt != 0) & (osd != G_MPX)`
  - `ds_resp_ready = init & (rsp_cnt != G_RSP_DEPTH)`
  - `us_resp_valid = (rsp_cnt != 0)`
  - `active = (cmd_cnt != 0) | (rsp_cnt != 0) | (osd != 0)`
  - `ds_cmd_*` and `us_resp_*` data fields drive the FIFO head entry.
- **Handshake rules:**
  - `ds_cmd_valid` does not depend on `ds_cmd_ready`.
  - Head data stays stable while valid is high and unaccepted.
- **Simultaneous push and pop:** when the FIFO is not full, both operations take effect and the count is unchanged. When full, push is blocked because ready is 0. When empty, pop cannot occur because valid is 0.

## Timing
- **Reset values** (reset_n low at a clock edge): pointers, counts, `osd` and `init` all go to 0. Resulting outputs:
  - us_cmd_ready = 0, ds_resp_ready = 0
  - ds_cmd_valid = 0, us_resp_valid = 0
  - active = 0
  - Data outputs: don't-care
- **After release:** ready outputs rise one cycle after reset_n is first sampled high.
- **Reset mid-operation:** all buffered commands and responses are discarded and counters cleared. No output handshake is asserted during reset. The crossbar must be reset in the same cycle.
- **Latency:**
  - Command accepted at edge N: ds_cmd_valid can be 1 in cycle N+1 (no bypass).
  - Response accepted at edge M: us_resp_valid is 1 in cycle M+1.
  - Minimum round trip through the block is 2 cycles plus downstream latency.
- **Throughput:** one command and one response per cycle, given depth >= 2 and G_MPX not reached.
- **Ordering:** responses return to the master strictly in command order; the crossbar guarantees in-order responses per upstream port.

## Test plan
- **Decode:** G_BASE/G_MASK at defaults, commands at 0x0000_0010, 0x1000_0004 and 0x2000_0000 -> ds_cmd_hit = 2'b01, 2'b10, 2'b00, each appearing one cycle after acceptance with unchanged addr/wdata/wmask.
- **Back-pressure:** ds_cmd_ready held 0, four back-to-back commands (G_CMD_DEPTH=2) -> exactly 2 accepted, then us_cmd_ready = 0. Release ds_cmd_ready -> both drain in order and ready returns to 1 the cycle after the first pop.
- **Outstanding limit:** G_MPX=2, ds_cmd_ready = 1, responses withheld, three commands -> exactly 2 downstream handshakes, ds_cmd_valid = 0 with the third queued. One response -> third command issues the next cycle.
- **Response path:** responses rdata = 0xA5A5_0001 err=0, then 0xDEAD_BEEF err=1, with us_resp_ready = 0 -> ds_resp_ready drops to 0 after 2 entries. Raise us_resp_ready -> both delivered in order, err preserved.
- **Simultaneous events:** FIFOs at 1 entry, push and pop in the same cycle for 10 consecutive cycles -> counts stay at 1, full rate sustained, no data lost.
- **Reset mid-operation:** 2 commands buffered and 1 outstanding, reset_n low for 1 cycle -> next cycle active = 0, all valids 0, readies 0. One cycle later the readies are 1 and the buffered commands never appear downstream.
